// File: rtl/cost_eval_scheduler.sv
// Round-robin scheduler sharing one worker/job cost ROM port among NUM_REQ
// permutation-evaluation engines; walks 8 lookups and returns the total cost.
module cost_eval_scheduler #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [24*NUM_REQ-1:0]  perm,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [2:0]             W,
  output logic [2:0]             J,
  input  logic [6:0]             Cost,
  output logic [9:0]             sum,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy
);

  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PERM_W = 24;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned SUM_W  = 10;
  localparam int unsigned WORKERS = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOOKUP = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [PERM_W-1:0]   perm_q, perm_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SUM_W-1:0]    acc_q, acc_d;
  logic [2:0]          w_q, w_d;
  logic [2:0]          j_q, j_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                busy_q, busy_d;

  // Round-robin winner: first set req bit at or above ptr, wrapping.
  logic [2*NUM_REQ-1:0] req_rot;
  logic                 win_found;
  logic [PTR_W-1:0]     win;
  logic [PTR_W-1:0]     ptr_after;
  logic [PERM_W-1:0]    win_perm;
  int unsigned          cand;
  int unsigned          nxt;

  always_comb begin
    req_rot   = {req, req} >> ptr_q;
    win_found = 1'b0;
    win       = ptr_q;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_rot[i]) begin
        win_found = 1'b1;
        cand      = 32'(ptr_q) + i;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        win       = PTR_W'(cand);
      end
    end
    nxt = 32'(win) + 1;
    if (nxt >= NUM_REQ) nxt = 0;
    ptr_after = PTR_W'(nxt);
    win_perm  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (PTR_W'(i) == win) win_perm = perm[i*PERM_W +: PERM_W];
    end
  end

  // Job of the next worker from the captured assignment.
  logic [IDX_W-1:0] idx_inc;
  logic [2:0]       job_nx;

  always_comb begin
    idx_inc = idx_q + IDX_W'(1);
    job_nx  = '0;
    for (int unsigned w = 0; w < WORKERS; w++) begin
      if (IDX_W'(w) == idx_inc) job_nx = perm_q[3*w +: 3];
    end
  end

  logic [SUM_W-1:0] acc_next;

  always_comb begin
    state_d  = state_q;
    perm_d   = perm_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    w_d      = w_q;
    j_d      = j_q;
    sum_d    = sum_q;
    gnt_d    = '0;
    done_d   = '0;
    busy_d   = 1'b0;
    acc_next = acc_q + SUM_W'(Cost);
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = LOOKUP;
          perm_d  = win_perm;
          owner_d = win;
          gnt_d   = NUM_REQ'(1) << win;
          w_d     = '0;
          j_d     = win_perm[2:0];
          acc_d   = '0;
          idx_d   = '0;
          ptr_d   = ptr_after;
          busy_d  = 1'b1;
        end
      end
      LOOKUP: begin
        acc_d = acc_next;
        if (idx_q != IDX_W'(WORKERS - 1)) begin
          idx_d  = idx_inc;
          w_d    = idx_inc;
          j_d    = job_nx;
          busy_d = 1'b1;
        end else begin
          sum_d   = acc_next;
          done_d  = NUM_REQ'(1) << owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      perm_q  <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      w_q     <= '0;
      j_q     <= '0;
      sum_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      perm_q  <= perm_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      w_q     <= w_d;
      j_q     <= j_d;
      sum_q   <= sum_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign W    = w_q;
  assign J    = j_q;
  assign sum  = sum_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_cost_eval_scheduler.sv
// Scoreboard bench for cost_eval_scheduler: expected sums queued per engine at
// request time, a cycle monitor checks grants, lookups and completions.
module tb_cost_eval_scheduler;

  localparam int N = 2;
  localparam logic [23:0] IDENT = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [23:0] REV   = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    req;
  logic [24*N-1:0] perm;
  logic [N-1:0]    gnt;
  logic [2:0]      W;
  logic [2:0]      J;
  logic [6:0]      Cost;
  logic [9:0]      sum;
  logic [N-1:0]    done;
  logic            busy;

  cost_eval_scheduler #(.NUM_REQ(N)) dut (
    .CLK(CLK), .RST(RST), .req(req), .perm(perm), .gnt(gnt), .W(W), .J(J),
    .Cost(Cost), .sum(sum), .done(done), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // ROM model: 0 = W*J, 1 = all 127, 2 = random table
  int         rom_mode = 0;
  logic [6:0] rom_tab [64];

  function automatic int rom_val(int w, int j);
    case (rom_mode)
      0:       return w * j;
      1:       return 127;
      default: return int'(rom_tab[w*8 + j]);
    endcase
  endfunction

  assign Cost = 7'(rom_val(int'(W), int'(J)));

  function automatic int exp_sum(logic [23:0] p);
    int s = 0;
    for (int w = 0; w < 8; w++) s += rom_val(w, int'(p[3*w +: 3]));
    return s;
  endfunction

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction

  // Scoreboard and pending jobs
  int          exp_q [N][$];
  logic [23:0] jobs  [N][$];

  // Inputs as seen by the DUT at each rising edge
  logic [N-1:0]    req_e;
  logic [24*N-1:0] perm_e;
  logic            rst_e;
  always @(posedge CLK) begin
    req_e  <= req;
    perm_e <= perm;
    rst_e  <= RST;
  end

  // Behavioural model: -1 idle, else index of the worker being looked up
  int          m_lk = -1;
  int          m_owner = 0;
  int          m_ptr = 0;
  int          m_sum = 0;
  logic [23:0] m_perm = '0;

  always @(negedge CLK) begin
    logic [N-1:0] exp_g;
    logic [N-1:0] exp_d;
    bit           got;
    exp_g = '0;
    exp_d = '0;
    if (rst_e) begin
      m_lk = -1; m_ptr = 0; m_sum = 0;
      chk("rst_W", int'(W), 0);
      chk("rst_J", int'(J), 0);
    end else if (m_lk < 0) begin
      if (req_e != '0) begin
        got = 1'b0;
        for (int i = 0; i < N; i++) begin
          int c;
          c = (m_ptr + i) % N;
          if (!got && req_e[c]) begin
            got = 1'b1; m_owner = c;
          end
        end
        m_perm = perm_e[24*m_owner +: 24];
        m_ptr  = (m_owner + 1) % N;
        m_lk   = 0;
        exp_g[m_owner] = 1'b1;
      end
    end else if (m_lk < 7) begin
      m_lk++;
    end else begin
      m_lk = -1;
      exp_d[m_owner] = 1'b1;
      if (exp_q[m_owner].size() == 0) chk("scoreboard_empty", 0, 1);
      else m_sum = exp_q[m_owner].pop_front();
    end
    chk("gnt", int'(gnt), int'(exp_g));
    chk("done", int'(done), int'(exp_d));
    chk("busy", int'(busy), (m_lk >= 0) ? 1 : 0);
    chk("sum", int'(sum), m_sum);
    if (m_lk >= 0) begin
      chk("W", int'(W), m_lk);
      chk("J", int'(J), int'(m_perm[3*m_lk +: 3]));
    end
  end

  // Driver
  bit imm = 1'b1;

  task automatic launch(int i);
    logic [23:0] p;
    p = jobs[i].pop_front();
    perm[24*i +: 24] = p;
    req[i] = 1'b1;
    exp_q[i].push_back(exp_sum(p));
  endtask

  task automatic drive_cycle();
    @(negedge CLK);
    for (int i = 0; i < N; i++) begin
      if (req[i] && gnt[i]) begin
        if (jobs[i].size() > 0) launch(i);
        else req[i] = 1'b0;
      end else if (!req[i] && jobs[i].size() > 0 && (imm || $urandom_range(0, 3) == 0)) begin
        launch(i);
      end
    end
  endtask

  function automatic bit drained();
    for (int i = 0; i < N; i++)
      if (jobs[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    return (req == '0) && (m_lk < 0) && !busy;
  endfunction

  task automatic run(int maxc);
    int c = 0;
    while (!drained() && c < maxc) begin
      drive_cycle();
      c++;
    end
    if (!drained()) chk("drain_timeout", 0, 1);
    repeat (2) @(negedge CLK);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_gnt"}, int'(gnt), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_W"}, int'(W), 0);
    chk({tag, "_J"}, int'(J), 0);
    chk({tag, "_sum"}, int'(sum), 0);
  endtask

  // Called right after a falling edge; asserts RST within the current cycle.
  task automatic do_reset(string tag);
    #2;
    RST = 1'b1;
    req = '0;
    for (int i = 0; i < N; i++) begin
      jobs[i].delete();
      exp_q[i].delete();
    end
    #1;
    check_reset_outputs(tag);
    @(negedge CLK);
    @(negedge CLK);
    #2 RST = 1'b0;
  endtask

  initial begin
    int wc;
    RST  = 1'b1;
    req  = '0;
    perm = '0;
    for (int k = 0; k < 64; k++) rom_tab[k] = 7'($urandom());
    @(negedge CLK);
    @(negedge CLK);
    check_reset_outputs("por");
    #2 RST = 1'b0;

    // identity and reverse on engine 0
    imm = 1'b1;
    jobs[0].push_back(IDENT);
    run(100);
    jobs[0].push_back(REV);
    run(100);

    // simultaneous requests straight after reset
    @(negedge CLK);
    do_reset("rst2");
    jobs[0].push_back(24'($urandom()));
    jobs[1].push_back(24'($urandom()));
    run(100);

    // both engines held high for 6 evaluations
    for (int k = 0; k < 3; k++) begin
      jobs[0].push_back(24'($urandom()));
      jobs[1].push_back(24'($urandom()));
    end
    run(200);

    // all-127 ROM
    rom_mode = 1;
    jobs[0].push_back(24'($urandom()));
    jobs[1].push_back(REV);
    run(100);

    // reset during the W=3 lookup, then ptr must be back at 0
    rom_mode = 0;
    jobs[0].push_back(IDENT);
    wc = 0;
    do begin
      drive_cycle();
      wc++;
    end while (!(busy && W == 3'd3) && wc < 40);
    chk("w3_reached", int'(busy && W == 3'd3), 1);
    do_reset("rst_mid");
    jobs[0].push_back(IDENT);
    jobs[1].push_back(REV);
    run(100);

    // randomized traffic over a random ROM
    rom_mode = 2;
    imm = 1'b0;
    for (int k = 0; k < 20; k++) jobs[$urandom_range(0, N-1)].push_back(24'($urandom()));
    run(2000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cost_eval_scheduler.md
# cost_eval_scheduler

Shares the single worker/job cost ROM port (W, J → Cost) among NUM_REQ permutation-evaluation engines. Each engine submits a complete 8-worker assignment. The scheduler arbitrates round-robin, walks the 8 ROM lookups, and returns the 10-bit total cost with a done pulse to the owning engine. It sits between the assignment search engines and the cost ROM, so several engines can explore permutations in parallel over one lookup port.

## Interface
- NUM_REQ, 2, number of requesting engines (legal range 1..4).

Ports:
- CLK  in  1  clock, all state updates on the rising edge
- RST  in  1  reset RST, asynchronous, active-high; clock CLK
- req  in  NUM_REQ  per-engine request, held high until the matching gnt bit is seen
- perm  in  24*NUM_REQ  packed assignment; engine i uses bits [24i+23:24i]; worker w's job is bits [3w+2:3w] of that slice
- gnt  out  NUM_REQ  one-hot, one-cycle grant; perm of the granted engine has been captured
- W  out  3  worker index to the ROM
- J  out  3  job index to the ROM
- Cost  in  7  ROM data, combinational from the current W/J
- sum  out  10  total cost of the last completed evaluation; held until the next completion
- done  out  NUM_REQ  one-hot, one-cycle completion strobe for the owning engine
- busy  out  1  high while an evaluation is in progress (state LOOKUP)

## Operation
- The FSM has two states: IDLE and LOOKUP.
- **IDLE, req != 0 at an edge:**
  - Winner k is the first set req bit, searching upward from ptr and wrapping modulo NUM_REQ.
  - At that edge: perm_reg <= perm slice k; owner <= k; gnt[k] <= 1; W <= 0; J <= perm_reg job 0 (taken directly from slice k); acc <= 0; idx <= 0; ptr <= (k+1) mod NUM_REQ; state <= LOOKUP.
- **IDLE, req == 0:** hold all registers; gnt and done are 0.
- **LOOKUP, each edge:** acc <= acc + Cost (7-bit value zero-extended to 10 bits).
  - If idx < 7: idx <= idx+1; W <= idx+1; J <= job idx+1 of perm_reg.
  - If idx == 7: sum <= acc + Cost; done[owner] <= 1; state <= IDLE.
- req is ignored while in LOOKUP. Requests that arrive during LOOKUP are arbitrated at the first edge spent in IDLE.
- perm contents are not checked. Repeated or non-permutation job values are evaluated as given.
- **Width:** the maximum total is 8*127 = 1016 < 1024, so no overflow or saturation logic is present.
- **NUM_REQ = 1:** ptr is stuck at 0, and grants go to engine 0 only.
- **Requester rules:**
  - Keep req and perm stable from assertion until gnt.
  - Drop req in the cycle gnt is seen, or keep it high to queue the next evaluation. A req still high at an IDLE edge is a new request.

## Timing
- **Reset values:** state IDLE; gnt 0; done 0; W 0; J 0; sum 0; busy 0; ptr 0; acc 0; idx 0.
- **Reset asserted mid-LOOKUP:** the evaluation is aborted, no done is issued, and ptr returns to 0.
- **Grant:** gnt[k] is high the cycle after the edge that samples req; that is the first LOOKUP cycle, with W=0.
- **Lookup sequence:** W/J present pairs 0..7 in the 8 cycles after the grant edge, one per cycle, and Cost is sampled at the end of each.
- **Completion:** done[k] and the new sum become visible 8 cycles after gnt[k] rises, in the first IDLE cycle.
- **Throughput:** one evaluation per 9 cycles with back-to-back requests. The next gnt rises the cycle after done.
- **busy:** high exactly during the 8 LOOKUP cycles, which coincide with gnt and W=0..7.
- **Simultaneous requests:** after reset, engine 0 wins. Thereafter the most recently granted engine has the lowest priority.

## Test plan
- Single request, engine 0, perm = identity (job w = w), ROM Cost = W*J → gnt[0] for one cycle; W/J step 0/0..7/7; done[0] 8 cycles after gnt; sum = 140.
- Same setup with perm = reverse (job w = 7-w) → sum = 56; done only on bit 0; the done bit for engine 1 stays 0.
- req0 and req1 both asserted the cycle after reset, distinct perms → gnt[0] first, done[0], then gnt[1] the next cycle, done[1] 8 cycles later; each sum matches its own perm.
- req0 and req1 held high continuously for 6 evaluations → grant order 0,1,0,1,0,1; 9-cycle spacing between gnt pulses.
- ROM returns 127 for all addresses, any perm → sum = 1016, no wrap.
- RST pulsed during the 4th lookup cycle (W=3) → all outputs return to reset values immediately, no done. A subsequent identity request (Cost = W*J) completes with sum = 140 after the normal latency.
